peri_gpio_mp: RTL and testbench

- Parametrised multi-pin GPIO peripheral on the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata); next generation of the single-register pin-write peripheral.
- Adds direction control, synchronised input readback, and per-pin edge interrupts.
- Occupies a 32-byte window at BASE_ADDR; feeds the SoC read mux via peri_addr_ok and the CPU IRQ line via irq.

---
 rtl/peri_gpio_pkg.sv | 12 +
 rtl/peri_gpio_mp_debounce.sv | 30 +++
 rtl/peri_gpio_mp.sv | 134 +++++++++++++
 tb/tb_peri_gpio_mp.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/peri_gpio_pkg.sv
// Shared constants for the peri_gpio_mp GPIO block: register byte offsets,
// bus window size and the value returned for reserved offsets.
package peri_gpio_pkg;
  localparam logic [4:0]  GPIO_OFS_OUT  = 5'h00;
  localparam logic [4:0]  GPIO_OFS_DIR  = 5'h04;
  localparam logic [4:0]  GPIO_OFS_IN   = 5'h08;
  localparam logic [4:0]  GPIO_OFS_EN   = 5'h0C;
  localparam logic [4:0]  GPIO_OFS_STAT = 5'h10;
  localparam logic [4:0]  GPIO_OFS_POL  = 5'h14;
  localparam int          GPIO_WINDOW   = 32;
  localparam logic [31:0] GPIO_RSVD_RD  = 32'h0;
endpackage

// File: rtl/peri_gpio_mp_debounce.sv
// Single-pin debouncer: din follows sync_in only after the two have
// disagreed for DEBOUNCE_CYCLES consecutive cycles. Used by peri_gpio_mp
// when GPIO_DEBOUNCE_EN is defined.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic din
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;

  // Count disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      din <= 1'b0;
    end else if (sync_in == din) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      din <= sync_in;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/peri_gpio_mp.sv
// Multi-pin GPIO on the PicoRV32 native bus: OUT/DIR registers, synchronised
// (optionally debounced) input readback and per-pin edge interrupts with
// write-1-to-clear status. Optional debounce: define GPIO_DEBOUNCE_EN.
module peri_gpio_mp
  import peri_gpio_pkg::*;
#(
  parameter int          WIDTH           = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h0300_0000,
  parameter logic [31:0] OUT_RESET       = 32'h0,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  output logic             ready,
  input  logic [31:0]      addr,
  output logic [31:0]      rdata,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      wdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq,
  output logic             peri_addr_ok
);
  localparam int AW = $clog2(GPIO_WINDOW);

  logic [WIDTH-1:0] out_r, dir_r, en_r, stat_r, pol_r;
  logic [WIDTH-1:0] sync1, sync, din, prev;
  logic [WIDTH-1:0] rise, fall, evt, w1c, wmask, wd;
  logic [1:0]       prime;
  logic [31:0]      bmask, rd_mux;
  logic [4:0]       ofs;
  logic             acc, wr;
  logic             unused_ok;

  assign peri_addr_ok = valid && (addr[31:AW] == BASE_ADDR[31:AW]);
  // One accept per transaction: the ack cycle itself never accepts.
  assign acc   = peri_addr_ok && !ready;
  assign wr    = acc && (wstrb != 4'h0);
  assign ofs   = {addr[AW-1:2], 2'b00};
  assign bmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign wmask = bmask[WIDTH-1:0];
  assign wd    = wdata[WIDTH-1:0];
  assign w1c   = (wr && ofs == GPIO_OFS_STAT) ? (wd & wmask) : '0;

  assign pin_out = out_r;
  assign pin_oe  = dir_r;

  assign unused_ok = &{1'b0, addr[1:0], wdata, bmask};

  // Two-flop synchroniser for the asynchronous pads.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= pin_in;
      sync  <= sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .sync_in (sync[g]),
      .din     (din[g])
    );
  end
`else
  assign din = sync;
`endif

  assign rise = din & ~prev;
  assign fall = ~din & prev;
  // Events are held off until the input pipeline has filled after reset.
  assign evt  = (prime == 2'd3) ? ((pol_r & fall) | (~pol_r & rise)) : '0;

  // Previous-input history and saturating prime counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= '0;
      prime <= 2'd0;
    end else begin
      prev <= din;
      if (prime != 2'd3) prime <= prime + 2'd1;
    end
  end

  // Register read mux; reserved offsets read as zero.
  always_comb begin
    rd_mux = GPIO_RSVD_RD;
    case (ofs)
      GPIO_OFS_OUT:  rd_mux = 32'(out_r);
      GPIO_OFS_DIR:  rd_mux = 32'(dir_r);
      GPIO_OFS_IN:   rd_mux = 32'(din);
      GPIO_OFS_EN:   rd_mux = 32'(en_r);
      GPIO_OFS_STAT: rd_mux = 32'(stat_r);
      GPIO_OFS_POL:  rd_mux = 32'(pol_r);
      default:       rd_mux = GPIO_RSVD_RD;
    endcase
  end

  // Bus handshake, register writes, interrupt status and level irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready  <= 1'b0;
      rdata  <= 32'h0;
      out_r  <= OUT_RESET[WIDTH-1:0];
      dir_r  <= '0;
      en_r   <= '0;
      stat_r <= '0;
      pol_r  <= '0;
      irq    <= 1'b0;
    end else begin
      ready <= acc;
      rdata <= (acc && wstrb == 4'h0) ? rd_mux : 32'h0;
      if (wr) begin
        case (ofs)
          GPIO_OFS_OUT: out_r <= (out_r & ~wmask) | (wd & wmask);
          GPIO_OFS_DIR: dir_r <= (dir_r & ~wmask) | (wd & wmask);
          GPIO_OFS_EN:  en_r  <= (en_r  & ~wmask) | (wd & wmask);
          GPIO_OFS_POL: pol_r <= (pol_r & ~wmask) | (wd & wmask);
          default: ;
        endcase
      end
      // A new event on the same edge as its clear keeps the bit set.
      stat_r <= (stat_r & ~w1c) | evt;
      irq    <= |(stat_r & en_r);
    end
  end
endmodule

// File: tb/tb_peri_gpio_mp.sv
// Directed bench for peri_gpio_mp: bus handshake, strobes, reserved space,
// edge interrupts, W1C/event collision and the post-reset prime mask.
module tb_peri_gpio_mp;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] B = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset, valid, ready, irq, peri_addr_ok;
  logic [31:0] addr, rdata, wdata, d;
  logic [3:0]  wstrb;
  logic [9:0]  pin_in, pin_out, pin_oe;
  int          total = 0;
  int          bad = 0;

  peri_gpio_mp dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .addr(addr),
    .rdata(rdata), .wstrb(wstrb), .wdata(wdata), .pin_in(pin_in),
    .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq), .peri_addr_ok(peri_addr_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
    valid = 1'b1; addr = a; wdata = v; wstrb = s;
    @(posedge clk); #1;
    chk("wr_ack", {31'b0, ready}, 32'd1);
    valid = 1'b0; wstrb = 4'h0;
    @(negedge clk); @(posedge clk); @(negedge clk);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    valid = 1'b1; addr = a; wdata = 32'h0; wstrb = 4'h0;
    @(posedge clk); #1;
    chk("rd_ack", {31'b0, ready}, 32'd1);
    v = rdata;
    valid = 1'b0;
    @(negedge clk); @(posedge clk); @(negedge clk);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0; pin_in = '0;
    cyc(3);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_out", {22'b0, pin_out}, 32'h0);
    chk("rst_oe", {22'b0, pin_oe}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b0;
    cyc(1);

    // Address decode is combinational and window-limited.
    valid = 1'b1; addr = B + 32'h1C; #1;
    chk("hit_in", {31'b0, peri_addr_ok}, 32'd1);
    addr = B + 32'h20; #1;
    chk("hit_out", {31'b0, peri_addr_ok}, 32'd0);
    @(posedge clk); #1;
    chk("miss_noack", {31'b0, ready}, 32'd0);
    valid = 1'b0;
    @(negedge clk);

    // Write OUT with valid held across the ack cycle: single ack only.
    valid = 1'b1; addr = B; wdata = 32'h0000_02A5; wstrb = 4'hF;
    @(posedge clk); #1;
    chk("hold_ack1", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    chk("hold_noack2", {31'b0, ready}, 32'd0);
    valid = 1'b0; wstrb = 4'h0;
    @(negedge clk);
    chk("pin_out", {22'b0, pin_out}, 32'h2A5);
    bus_rd(B, d); chk("rd_out", d, 32'h2A5);

    // Lane-0-only write to DIR; reserved space.
    bus_wr(B + 32'h04, 32'h0000_FFFF, 4'h1);
    chk("pin_oe", {22'b0, pin_oe}, 32'h0FF);
    bus_rd(B + 32'h04, d); chk("rd_dir", d, 32'h0FF);
    bus_wr(B + 32'h18, 32'hFFFF_FFFF, 4'hF);
    bus_rd(B + 32'h18, d); chk("rd_rsv18", d, 32'h0);
    bus_rd(B + 32'h1C, d); chk("rd_rsv1c", d, 32'h0);

    // Lane 1 write to OUT touches only bits [9:8].
    bus_wr(B, 32'hFFFF_FFFF, 4'h2);
    bus_rd(B, d); chk("rd_out_ln1", d, 32'h3A5);

    // Rising edge on pin 0 with IRQ enabled.
    bus_wr(B + 32'h0C, 32'h1, 4'hF);
    pin_in = 10'h001;
    for (int i = 1; i <= LAT + 2; i++) begin
      cyc(1);
      if (i == LAT + 1) chk("irq_lag", {31'b0, irq}, 32'd0);
      if (i == LAT + 2) chk("irq_set", {31'b0, irq}, 32'd1);
    end
    bus_rd(B + 32'h10, d); chk("stat_rise", d, 32'h1);
    bus_rd(B + 32'h08, d); chk("in_pin0", d, 32'h1);
    bus_wr(B + 32'h10, 32'h1, 4'hF);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    bus_rd(B + 32'h10, d); chk("stat_clr", d, 32'h0);

    // Falling edge with rising polarity: no event.
    pin_in = 10'h000;
    cyc(LAT + 3);
    bus_rd(B + 32'h10, d); chk("stat_nofall", d, 32'h0);

    // Clear on the same edge a new rising event lands: event wins.
    pin_in = 10'h001;
    cyc(LAT);
    bus_wr(B + 32'h10, 32'h1, 4'hF);
    bus_rd(B + 32'h10, d); chk("stat_collide", d, 32'h1);
    bus_wr(B + 32'h10, 32'h3FF, 4'hF);

    // Per-pin polarity: pin 0 falling, pin 2 rising.
    bus_wr(B + 32'h14, 32'h1, 4'hF);
    pin_in = 10'h004;
    cyc(LAT + 2);
    bus_rd(B + 32'h10, d); chk("stat_pol", d, 32'h5);
    chk("irq_pol", {31'b0, irq}, 32'd1);
    bus_wr(B + 32'h10, 32'h3FF, 4'hF);
    chk("irq_pol_clr", {31'b0, irq}, 32'd0);

    // Pin 3 held high through reset: prime mask hides the fill-up edge.
    pin_in = 10'h008;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    chk("rst2_oe", {22'b0, pin_oe}, 32'h0);
    cyc(LAT + 4);
    bus_rd(B + 32'h10, d); chk("stat_prime", d, (LAT == 2) ? 32'h0 : 32'h8);
    bus_rd(B + 32'h08, d); chk("in_pin3", d, 32'h8);

`ifdef GPIO_DEBOUNCE_EN
    bus_wr(B + 32'h0C, 32'h2, 4'hF);
    pin_in = 10'h000;
    cyc(25);
    bus_wr(B + 32'h10, 32'h3FF, 4'hF);
    pin_in = 10'h002;
    cyc(10);
    pin_in = 10'h000;
    cyc(25);
    bus_rd(B + 32'h08, d); chk("db_glitch_in", d, 32'h0);
    bus_rd(B + 32'h10, d); chk("db_glitch_stat", d, 32'h0);
    chk("db_glitch_irq", {31'b0, irq}, 32'd0);
    pin_in = 10'h002;
    cyc(18);
    bus_rd(B + 32'h08, d); chk("db_pulse_in", d, 32'h2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
